// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file write arbiter: default widths,
// writeback-source encoding, write-request record and write-port source tags.
package regfile_pkg;

    localparam int DEF_DATA_W     = 32;
    localparam int DEF_REG_ADDR_W = 5;

    // mem_wb_sel encoding; the fourth code is reserved and behaves as ALU
    localparam logic [1:0] WB_ALU  = 2'd0;
    localparam logic [1:0] WB_LOAD = 2'd1;
    localparam logic [1:0] WB_LINK = 2'd2;

    // One register-file write at the default widths
    typedef struct packed {
        logic [DEF_REG_ADDR_W-1:0] dest;
        logic [DEF_DATA_W-1:0]     data;
    } wr_req_t;

    // Which requester owns the write port in a given cycle
    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_PIPE = 2'd1,
        SRC_BUF  = 2'd2,
        SRC_LU   = 2'd3
    } wr_src_e;

endpackage

// File: rtl/regfile_write_arbiter_wb_hold_buffer.sv
// wb_hold_buffer: single-entry holding slot for a long-unit result that lost
// the write port to the pipeline, plus the counter of consecutive losses.
// starved rises once the entry has lost STARVE_LIMIT times in a row.
module wb_hold_buffer
    import regfile_pkg::*;
#(
    parameter int DATA_W       = DEF_DATA_W,
    parameter int REG_ADDR_W   = DEF_REG_ADDR_W,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [REG_ADDR_W-1:0] load_dest,
    input  logic [DATA_W-1:0]     load_data,
    input  logic                  drain,
    input  logic                  lose,
    output logic                  full,
    output logic [REG_ADDR_W-1:0] buf_dest,
    output logic [DATA_W-1:0]     buf_data,
    output logic                  starved
);

    logic                  full_q, full_d;
    logic [REG_ADDR_W-1:0] dest_q, dest_d;
    logic [DATA_W-1:0]     data_q, data_d;
    logic [3:0]            starve_cnt_q, starve_cnt_d;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    // Load only happens into an empty slot and drain only from a full one,
    // so the two never collide; the loss counter restarts on every drain.
    always_comb begin
        full_d       = full_q;
        dest_d       = dest_q;
        data_d       = data_q;
        starve_cnt_d = starve_cnt_q;
        if (load) begin
            full_d       = 1'b1;
            dest_d       = load_dest;
            data_d       = load_data;
            starve_cnt_d = '0;
        end else if (drain) begin
            full_d       = 1'b0;
            starve_cnt_d = '0;
        end else if (lose && full_q && starve_cnt_q != LIMIT) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end
    end

    // Slot and counter registers, cleared by the active-low synchronous reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            full_q       <= 1'b0;
            dest_q       <= '0;
            data_q       <= '0;
            starve_cnt_q <= '0;
        end else begin
            full_q       <= full_d;
            dest_q       <= dest_d;
            data_q       <= data_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    assign full     = full_q;
    assign buf_dest = dest_q;
    assign buf_data = data_q;
    assign starved  = full_q && (starve_cnt_q == LIMIT);

endmodule

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: owns the MEM/WB boundary. Picks the writeback source
// for the pipelined instruction, merges long-unit (mult/div) results into the
// single register-file write port and stalls MEM when a buffered long-unit
// result has lost arbitration too often.
// Optional build macro REGFILE_PENDING_SCOREBOARD_EN adds a per-register
// pending bitmap for in-flight long-unit destinations.
module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter int DATA_W       = DEF_DATA_W,
    parameter int REG_ADDR_W   = DEF_REG_ADDR_W,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     mem_valid,
    input  logic                     mem_reg_write,
    input  logic [1:0]               mem_wb_sel,
    input  logic [REG_ADDR_W-1:0]    mem_dest,
    input  logic [DATA_W-1:0]        mem_alu_result,
    input  logic [DATA_W-1:0]        mem_load_data,
    input  logic [DATA_W-1:0]        mem_link_addr,
    output logic                     mem_ready,
    input  logic                     lu_req,
    input  logic [REG_ADDR_W-1:0]    lu_dest,
    input  logic [DATA_W-1:0]        lu_data,
`ifdef REGFILE_PENDING_SCOREBOARD_EN
    input  logic                     lu_issue,
    input  logic [REG_ADDR_W-1:0]    lu_issue_dest,
    output logic [2**REG_ADDR_W-1:0] pending,
`endif
    output logic                     lu_ack,
    output logic [REG_ADDR_W-1:0]    Write_Reg,
    output logic [DATA_W-1:0]        Write_Data,
    output logic                     Reg_Write
);

    logic [REG_ADDR_W-1:0] write_reg_q, write_reg_d;
    logic [DATA_W-1:0]     write_data_q, write_data_d;
    logic                  reg_write_q, reg_write_d;

    logic [DATA_W-1:0]     pipe_data;
    logic                  pw;
    logic                  lu_keep;
    wr_src_e               src;

    logic                  buf_full;
    logic [REG_ADDR_W-1:0] buf_dest;
    logic [DATA_W-1:0]     buf_data;
    logic                  starved;
    logic                  buf_load;
    logic                  buf_drain;
    logic                  buf_lose;

    // Writeback source mux for the instruction in MEM (reserved code -> ALU)
    always_comb begin
        pipe_data = mem_alu_result;
        case (mem_wb_sel)
            WB_LOAD: pipe_data = mem_load_data;
            WB_LINK: pipe_data = mem_link_addr;
            default: pipe_data = mem_alu_result;
        endcase
    end

    // During reset MEM is never held and no long-unit result is accepted
    assign mem_ready = !reset || !starved;
    assign pw        = mem_valid && mem_reg_write && (mem_dest != '0) && mem_ready;
    assign lu_ack    = lu_req && !buf_full && reset;
    // r0 results are acknowledged but dropped
    assign lu_keep   = lu_ack && (lu_dest != '0);

    // Write-port arbitration: starved buffer, then pipeline, then buffer,
    // then a direct long-unit write; the winner is registered at the edge.
    always_comb begin
        src          = SRC_NONE;
        reg_write_d  = 1'b0;
        write_reg_d  = write_reg_q;
        write_data_d = write_data_q;
        if (buf_full && !mem_ready) begin
            src = SRC_BUF;
        end else if (pw) begin
            src = SRC_PIPE;
        end else if (buf_full) begin
            src = SRC_BUF;
        end else if (lu_keep) begin
            src = SRC_LU;
        end
        case (src)
            SRC_PIPE: begin
                reg_write_d  = 1'b1;
                write_reg_d  = mem_dest;
                write_data_d = pipe_data;
            end
            SRC_BUF: begin
                reg_write_d  = 1'b1;
                write_reg_d  = buf_dest;
                write_data_d = buf_data;
            end
            SRC_LU: begin
                reg_write_d  = 1'b1;
                write_reg_d  = lu_dest;
                write_data_d = lu_data;
            end
            default: begin
                reg_write_d = 1'b0;
            end
        endcase
    end

    // An accepted long-unit result that collides with a pipeline write parks
    // in the holding buffer; the buffer drains whenever it wins the port.
    assign buf_load  = lu_keep && pw;
    assign buf_drain = (src == SRC_BUF);
    assign buf_lose  = buf_full && (src == SRC_PIPE);

    wb_hold_buffer #(
        .DATA_W       (DATA_W),
        .REG_ADDR_W   (REG_ADDR_W),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_hold (
        .clk       (clk),
        .reset     (reset),
        .load      (buf_load),
        .load_dest (lu_dest),
        .load_data (lu_data),
        .drain     (buf_drain),
        .lose      (buf_lose),
        .full      (buf_full),
        .buf_dest  (buf_dest),
        .buf_data  (buf_data),
        .starved   (starved)
    );

    // Register-file write port registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            reg_write_q  <= 1'b0;
            write_reg_q  <= '0;
            write_data_q <= '0;
        end else begin
            reg_write_q  <= reg_write_d;
            write_reg_q  <= write_reg_d;
            write_data_q <= write_data_d;
        end
    end

    assign Reg_Write  = reg_write_q;
    assign Write_Reg  = write_reg_q;
    assign Write_Data = write_data_q;

`ifdef REGFILE_PENDING_SCOREBOARD_EN
    localparam int NUM_REGS = 2**REG_ADDR_W;

    logic [NUM_REGS-1:0]   pending_q, pending_d;
    logic                  lu_wr_fire;
    logic [REG_ADDR_W-1:0] lu_wr_dest;

    // A long-unit write is one coming from the buffer or straight from the unit
    assign lu_wr_fire = (src == SRC_BUF) || (src == SRC_LU);
    assign lu_wr_dest = (src == SRC_BUF) ? buf_dest : lu_dest;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_pending
            if (gi == 0) begin : g_r0
                // r0 is never written, so it is never tracked
                assign pending_d[gi] = 1'b0;
            end else begin : g_rn
                // Per-register set/clear; a new issue beats a retiring write
                always_comb begin
                    pending_d[gi] = pending_q[gi];
                    if (lu_wr_fire && lu_wr_dest == REG_ADDR_W'(gi)) begin
                        pending_d[gi] = 1'b0;
                    end
                    if (lu_issue && lu_issue_dest == REG_ADDR_W'(gi)) begin
                        pending_d[gi] = 1'b1;
                    end
                end
            end
        end
    endgenerate

    // Pending bitmap register, cleared by reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign pending = pending_q;
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed self-checking bench for regfile_write_arbiter. Inputs change 1ns
// after a rising edge; outputs are sampled before the next rising edge.
// Define REGFILE_PENDING_SCOREBOARD_EN to also exercise the pending bitmap.
module tb_regfile_write_arbiter;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          mem_valid, mem_reg_write;
    logic [1:0]    mem_wb_sel;
    logic [AW-1:0] mem_dest;
    logic [DW-1:0] mem_alu_result, mem_load_data, mem_link_addr;
    logic          mem_ready;
    logic          lu_req;
    logic [AW-1:0] lu_dest;
    logic [DW-1:0] lu_data;
    logic          lu_ack;
    logic [AW-1:0] Write_Reg;
    logic [DW-1:0] Write_Data;
    logic          Reg_Write;
`ifdef REGFILE_PENDING_SCOREBOARD_EN
    logic          lu_issue;
    logic [AW-1:0] lu_issue_dest;
    logic [2**AW-1:0] pending;
`endif

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    regfile_write_arbiter #(
        .DATA_W       (DW),
        .REG_ADDR_W   (AW),
        .STARVE_LIMIT (4)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .mem_valid      (mem_valid),
        .mem_reg_write  (mem_reg_write),
        .mem_wb_sel     (mem_wb_sel),
        .mem_dest       (mem_dest),
        .mem_alu_result (mem_alu_result),
        .mem_load_data  (mem_load_data),
        .mem_link_addr  (mem_link_addr),
        .mem_ready      (mem_ready),
        .lu_req         (lu_req),
        .lu_dest        (lu_dest),
        .lu_data        (lu_data),
`ifdef REGFILE_PENDING_SCOREBOARD_EN
        .lu_issue       (lu_issue),
        .lu_issue_dest  (lu_issue_dest),
        .pending        (pending),
`endif
        .lu_ack         (lu_ack),
        .Write_Reg      (Write_Reg),
        .Write_Data     (Write_Data),
        .Reg_Write      (Reg_Write)
    );

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        total_cnt++;
        assert (observed === expected) pass_cnt++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        $display("check %-14s observed=0x%0h expected=0x%0h", tag, observed, expected);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_wr(input string tag, input logic rw, input logic [AW-1:0] wr, input logic [DW-1:0] wd);
        check({tag, ".rw"}, 64'(Reg_Write), 64'(rw));
        check({tag, ".wr"}, 64'(Write_Reg), 64'(wr));
        check({tag, ".wd"}, 64'(Write_Data), 64'(wd));
    endtask

    initial begin
        reset          = 1'b0;
        mem_valid      = 1'b0;
        mem_reg_write  = 1'b0;
        mem_wb_sel     = 2'd0;
        mem_dest       = '0;
        mem_alu_result = 32'h1111_1111;
        mem_load_data  = 32'hDEAD_BEEF;
        mem_link_addr  = 32'h2222_2222;
        lu_req         = 1'b1;
        lu_dest        = 5'd9;
        lu_data        = 32'h12;
`ifdef REGFILE_PENDING_SCOREBOARD_EN
        lu_issue       = 1'b0;
        lu_issue_dest  = '0;
`endif
        // Reset state: lu_ack suppressed and mem_ready high while in reset
        tick();
        tick();
        check_wr("reset", 1'b0, 5'd0, 32'h0);
        check("reset.ready", 64'(mem_ready), 64'd1);
        check("reset.ack", 64'(lu_ack), 64'd0);
        lu_req = 1'b0;
        reset  = 1'b1;
        tick();
        check("idle.rw", 64'(Reg_Write), 64'd0);

        // Writeback source selection, one cycle latency
        mem_valid = 1'b1; mem_reg_write = 1'b1; mem_wb_sel = 2'd1; mem_dest = 5'd5;
        tick();
        check_wr("sel_load", 1'b1, 5'd5, 32'hDEAD_BEEF);
        mem_wb_sel = 2'd0; mem_dest = 5'd6;
        tick();
        check_wr("sel_alu", 1'b1, 5'd6, 32'h1111_1111);
        mem_wb_sel = 2'd2; mem_dest = 5'd7;
        tick();
        check_wr("sel_link", 1'b1, 5'd7, 32'h2222_2222);
        mem_wb_sel = 2'd3; mem_dest = 5'd8;
        tick();
        check_wr("sel_rsvd", 1'b1, 5'd8, 32'h1111_1111);

        // r0 destination and non-writing instruction: no write, outputs hold
        mem_dest = 5'd0;
        tick();
        check_wr("dest_r0", 1'b0, 5'd8, 32'h1111_1111);
        mem_dest = 5'd9; mem_reg_write = 1'b0;
        tick();
        check("no_regwr.rw", 64'(Reg_Write), 64'd0);

        // Direct long-unit write with the pipeline idle
        mem_valid = 1'b0;
        lu_req = 1'b1; lu_dest = 5'd9; lu_data = 32'h12;
        #1;
        check("lu_direct.ack", 64'(lu_ack), 64'd1);
        tick();
        lu_req = 1'b0;
        check_wr("lu_direct", 1'b1, 5'd9, 32'h12);

        // Long-unit result to r0 is acked but discarded
        lu_req = 1'b1; lu_dest = 5'd0; lu_data = 32'h55;
        #1;
        check("lu_r0.ack", 64'(lu_ack), 64'd1);
        tick();
        lu_req = 1'b0;
        check("lu_r0.rw", 64'(Reg_Write), 64'd0);
        tick();
        check("lu_r0.nobuf", 64'(Reg_Write), 64'd0);

        // Starvation: pipeline writes r3 every cycle, r7 parked in the buffer
        mem_valid = 1'b1; mem_reg_write = 1'b1; mem_wb_sel = 2'd0; mem_dest = 5'd3;
        mem_alu_result = 32'h100;
        lu_req = 1'b1; lu_dest = 5'd7; lu_data = 32'hAA;
        #1;
        check("stv.ack0", 64'(lu_ack), 64'd1);
        tick();
        lu_req = 1'b0;
        check_wr("stv.c0", 1'b1, 5'd3, 32'h100);
        for (int i = 1; i <= 4; i++) begin
            mem_alu_result = 32'h100 + 32'(i);
            if (i == 2) begin
                lu_req = 1'b1; lu_dest = 5'd10; lu_data = 32'hBB;
            end
            #1;
            check("stv.ready", 64'(mem_ready), 64'd1);
            if (i >= 2) check("full.noack", 64'(lu_ack), 64'd0);
            tick();
            check_wr("stv.pipe", 1'b1, 5'd3, 32'h100 + 32'(i));
        end
        // Fifth attempt: MEM stalled, buffer forced out
        mem_alu_result = 32'h105;
        #1;
        check("stv.stall", 64'(mem_ready), 64'd0);
        check("stv.stall_ack", 64'(lu_ack), 64'd0);
        tick();
        check_wr("stv.drain", 1'b1, 5'd7, 32'hAA);
        check("stv.ready_back", 64'(mem_ready), 64'd1);
        check("after.ack", 64'(lu_ack), 64'd1);
        tick();
        lu_req = 1'b0;
        check_wr("stv.held", 1'b1, 5'd3, 32'h105);
        mem_valid = 1'b0;
        tick();
        check_wr("buf.drain2", 1'b1, 5'd10, 32'hBB);
        tick();
        check("buf.empty", 64'(Reg_Write), 64'd0);

        // Reset with the buffer full and a write in flight
        mem_valid = 1'b1; mem_dest = 5'd4; mem_wb_sel = 2'd0; mem_alu_result = 32'h44;
        lu_req = 1'b1; lu_dest = 5'd11; lu_data = 32'hCC;
        tick();
        lu_req = 1'b0;
        check_wr("rst.pre", 1'b1, 5'd4, 32'h44);
        reset = 1'b0; mem_valid = 1'b0;
        #1;
        check("rst.ready", 64'(mem_ready), 64'd1);
        tick();
        check_wr("rst.mid", 1'b0, 5'd0, 32'h0);
        reset = 1'b1;
        tick();
        check("rst.bufgone", 64'(Reg_Write), 64'd0);
        mem_valid = 1'b1; mem_dest = 5'd6; mem_wb_sel = 2'd2; mem_link_addr = 32'h66;
        tick();
        check_wr("rst.post", 1'b1, 5'd6, 32'h66);
        mem_valid = 1'b0;
        tick();

`ifdef REGFILE_PENDING_SCOREBOARD_EN
        // Pending bitmap: set on issue, cleared as the r12 write lands
        lu_issue = 1'b1; lu_issue_dest = 5'd12;
        tick();
        lu_issue = 1'b0;
        check("pend.set", 64'(pending[12]), 64'd1);
        lu_req = 1'b1; lu_dest = 5'd12; lu_data = 32'h77;
        tick();
        lu_req = 1'b0;
        check_wr("pend.wr", 1'b1, 5'd12, 32'h77);
        check("pend.clr", 64'(pending[12]), 64'd0);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    // Safety net so the run always terminates
    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Initiator side of the register-file write port.
- Owns the MEM/WB boundary and selects the writeback source: ALU result, load data, or link address.
- Merges late results from multi-cycle units (mult/div) into the single write port.
- Buffers one losing long-unit result and back-pressures the pipeline if that result is starved.
- Drives the register file's Write_Reg, Write_Data and Reg_Write.

Parameters:
DATA_W, 32, register/data width
REG_ADDR_W, 5, register index width
STARVE_LIMIT, 4, consecutive cycles a buffered long-unit result may lose arbitration before the pipeline is stalled (1..15)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-low reset
mem_valid  input  1  MEM stage holds a live instruction
mem_reg_write  input  1  instruction writes a GPR
mem_wb_sel  input  2  0=ALU, 1=load data, 2=link address, 3=reserved (treated as ALU)
mem_dest  input  REG_ADDR_W  destination register
mem_alu_result  input  DATA_W  ALU result
mem_load_data  input  DATA_W  load data
mem_link_addr  input  DATA_W  return address for JAL/JALR
mem_ready  output  1  pipeline may advance; 0 = MEM must hold its inputs
lu_req  input  1  long unit has a result; held until acked
lu_dest  input  REG_ADDR_W  long-unit destination
lu_data  input  DATA_W  long-unit result
lu_ack  output  1  long-unit result accepted this cycle (combinational)
Write_Reg  output  REG_ADDR_W  register-file write index (registered)
Write_Data  output  DATA_W  register-file write data (registered)
Reg_Write  output  1  register-file write enable (registered)

Behaviour:
- Reset, when reset==0 at posedge clk:
  - Reg_Write=0, Write_Reg=0, Write_Data=0.
  - Holding buffer empty; starve counter 0.
  - mem_ready=1; lu_ack=0 during reset.
- Pipeline write request:
  - pw = mem_valid & mem_reg_write & (mem_dest!=0) & mem_ready.
  - Data selected by mem_wb_sel.
- Write-port arbitration is evaluated each cycle. Winner is registered onto Write_* at the edge, so latency from inputs to Reg_Write is 1 cycle.
  - Priority 1: buffer full and mem_ready==0 → buffer drains.
  - Priority 2: pw → pipeline write.
  - Priority 3: buffer full → buffer drains.
  - Priority 4: lu_req with empty buffer → direct long-unit write.
  - Otherwise Reg_Write=0, Write_* hold their previous values.
- lu_ack = lu_req & buffer empty & reset==1.
  - On ack, the result goes to the write port if pipeline write is idle, else into the buffer.
  - lu_dest==0: acked and discarded; never written, never buffered.
- Starve counter:
  - Increments on each edge where the buffer is full and pw wins; cleared when the buffer drains.
  - mem_ready = !(counter==STARVE_LIMIT). In that cycle MEM inputs are ignored and the buffer drains.
- Writes to register 0 never assert Reg_Write.
- Buffered result and simultaneous pipeline write to the same register: the pipeline (younger in program order) is written first and the buffer afterward. Ordering is the long unit's responsibility; the block does not reorder.
- Reset mid-operation: the buffered result is dropped and lu_ack is not reissued. The long unit is reset by the same signal.

Optional Feature:
REGFILE_PENDING_SCOREBOARD_EN
- With it: adds an input lu_issue (1 bit) plus lu_issue_dest, and an output pending (2^REG_ADDR_W bits).
  - Bit set on lu_issue.
  - Bit cleared in the cycle the matching long-unit write reaches Reg_Write.
  - Set and clear on the same register in the same cycle: set wins.
  - Reset clears all bits.
- Without it: ports absent, no scoreboard state.

Decomposition:
- Shared package regfile_pkg:
  - DATA_W and REG_ADDR_W defaults.
  - wb_sel encoding constants WB_ALU, WB_LOAD, WB_LINK.
  - Write-request struct {dest, data}.
- One natural sub-module, wb_hold_buffer: 1-entry buffer with full flag, load, drain and the starve counter.

Test Plan:
1. mem_valid=1, mem_reg_write=1, mem_wb_sel=1, mem_dest=5, mem_load_data=0xDEADBEEF → next cycle Reg_Write=1, Write_Reg=5, Write_Data=0xDEADBEEF.
2. mem_dest=0 with mem_reg_write=1 → Reg_Write stays 0; lu_req, lu_dest=9, lu_data=0x12 with pipeline idle → lu_ack same cycle, next cycle Write_Reg=9, Write_Data=0x12.
3. Pipeline writes r3 every cycle and lu_req writes r7=0xAA → lu_ack in cycle 0, buffer full. After STARVE_LIMIT=4 losses, mem_ready=0 for exactly 1 cycle, then Write_Reg=7, Write_Data=0xAA; mem_ready returns to 1.
4. Buffer full, second lu_req → lu_ack=0 until the cycle after the buffer drains.
5. reset=0 asserted with buffer full and Reg_Write=1 → next edge Reg_Write=0, buffer empty; a subsequent pipeline write proceeds normally.
6. (REGFILE_PENDING_SCOREBOARD_EN) lu_issue r12 → pending[12]=1; the long-unit write of r12 reaches Reg_Write → pending[12]=0 the same cycle.
